// File: rtl/dmem_responder_if.sv
// Request/response bundle between a core (master) and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        mem_wen;
   logic        mem_ren;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [7:0]  wmask;
   logic [2:0]  rmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] rdata;
   logic        resp_err;

   modport master (
      output req_valid, mem_wen, mem_ren, addr, wdata, wmask, rmask, resp_ready,
      input  req_ready, resp_valid, rdata, resp_err
   );

   modport slave (
      input  req_valid, mem_wen, mem_ren, addr, wdata, wmask, rmask, resp_ready,
      output req_ready, resp_valid, rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one request in flight, byte/half/word loads and stores,
// illegal requests answered with resp_err after the same latency and without touching memory.
module dmem_responder #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 1024
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  wmask_q, wmask_d;
   logic [2:0]  rmask_q, rmask_d;
   logic        wen_q, wen_d;
   logic        ren_q, ren_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH];

   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          illegal;
   logic [31:0]   rd_shift;
   logic [31:0]   load_val;
   logic [3:0]    lane_mask;
   logic [31:0]   wdata_shift;
   logic          do_write;
   logic          unused_addr_hi;

   assign idx            = addr_q[AW+1:2];
   assign off            = addr_q[1:0];
   assign unused_addr_hi = ^addr_q[31:AW+2];

   // Legality decode of the latched request.
   always_comb begin
      illegal = (wen_q == ren_q);
      if (wen_q) begin
         case (wmask_q)
            8'h01:   illegal = illegal;
            8'h03:   illegal = illegal | off[0];
            8'h0F:   illegal = illegal | (off != 2'b00);
            default: illegal = 1'b1;
         endcase
      end else if (ren_q) begin
         case (rmask_q)
            3'b000, 3'b100: illegal = illegal;
            3'b001, 3'b101: illegal = illegal | off[0];
            3'b010:         illegal = illegal | (off != 2'b00);
            default:        illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      rd_shift = mem_q[idx] >> {off, 3'b000};
      case (rmask_q)
         3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b010:  load_val = rd_shift;
         3'b100:  load_val = {24'd0, rd_shift[7:0]};
         3'b101:  load_val = {16'd0, rd_shift[15:0]};
         default: load_val = 32'd0;
      endcase
      lane_mask   = wmask_q[3:0] << off;
      wdata_shift = wdata_q << {off, 3'b000};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      rmask_d  = rmask_q;
      wen_d    = wen_q;
      ren_d    = ren_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      do_write = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               wmask_d = bus.wmask;
               rmask_d = bus.rmask;
               wen_d   = bus.mem_wen;
               ren_d   = bus.mem_ren;
               cnt_d   = LatInit;
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               // Access cycle: memory is read/written here, so an earlier reset drops the store.
               do_write = wen_q & ~illegal;
               rdata_d  = (ren_q & ~illegal) ? load_val : 32'd0;
               err_d    = illegal;
               state_d  = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (bus.resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wmask_q <= 8'd0;
         rmask_q <= 3'd0;
         wen_q   <= 1'b0;
         ren_q   <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rmask_q <= rmask_d;
         wen_q   <= wen_d;
         ren_q   <= ren_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately outside the reset branch: contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_mask[b]) begin
               mem_q[idx][8*b +: 8] <= wdata_shift[8*b +: 8];
            end
         end
      end
   end

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.resp_valid = (state_q == StResp);
   assign bus.rdata      = rdata_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a reference memory model predicts each response,
// predictions are queued at accept and compared when the response handshake completes.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(
      .LATENCY (2),
      .DEPTH   (1024)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rd;
      logic        er;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [1024];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference behaviour: predicts the response and updates the model memory for legal stores.
   task automatic model(input logic wen, input logic ren, input logic [31:0] a,
                        input logic [31:0] wd, input logic [7:0] wm, input logic [2:0] rm,
                        output exp_t e);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      logic        bad;
      w   = ref_mem[a[11:2]];
      b   = w[8*a[1:0] +: 8];
      h   = (a[1] == 1'b0) ? w[15:0] : w[31:16];
      bad = (wen && ren) || (!wen && !ren);
      if (wen) begin
         if (wm == 8'h03) bad = bad || a[0];
         else if (wm == 8'h0F) bad = bad || (a[1:0] != 2'b00);
         else if (wm != 8'h01) bad = 1'b1;
      end else if (ren) begin
         if (rm == 3'b001 || rm == 3'b101) bad = bad || a[0];
         else if (rm == 3'b010) bad = bad || (a[1:0] != 2'b00);
         else if (rm != 3'b000 && rm != 3'b100) bad = 1'b1;
      end
      e.er = bad;
      e.rd = 32'd0;
      if (!bad && ren) begin
         case (rm)
            3'b000:  e.rd = 32'(signed'(b));
            3'b001:  e.rd = 32'(signed'(h));
            3'b100:  e.rd = {24'd0, b};
            3'b101:  e.rd = {16'd0, h};
            default: e.rd = w;
         endcase
      end
      if (!bad && wen) begin
         for (int i = 0; i < 4; i++) begin
            if (i >= a[1:0] && (i - a[1:0]) < 4 && wm[i - a[1:0]]) begin
               w[8*i +: 8] = wd[8*(i - a[1:0]) +: 8];
            end
         end
         ref_mem[a[11:2]] = w;
      end
   endtask

   task automatic garble();
      bus.addr    = $urandom;
      bus.wdata   = $urandom;
      bus.wmask   = 8'($urandom);
      bus.rmask   = 3'($urandom);
      bus.mem_wen = 1'($urandom);
      bus.mem_ren = 1'($urandom);
   endtask

   task automatic issue(input logic wen, input logic ren, input logic [31:0] a,
                        input logic [31:0] wd, input logic [7:0] wm, input logic [2:0] rm,
                        input int hold);
      exp_t e;
      int   lat;
      int   w;
      w = 0;
      while (!bus.req_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      check("req_ready_before", 32'(bus.req_ready), 32'd1);
      bus.mem_wen   = wen;
      bus.mem_ren   = ren;
      bus.addr      = a;
      bus.wdata     = wd;
      bus.wmask     = wm;
      bus.rmask     = rm;
      bus.req_valid = 1'b1;
      model(wen, ren, a, wd, wm, rm, e);
      sb.push_back(e);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      garble();
      lat = 0;
      while (!bus.resp_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
         garble();
      end
      check("latency", 32'(lat), 32'd2);
      bus.req_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(bus.resp_valid), 32'd1);
         check("hold_rdata", bus.rdata, sb[0].rd);
         check("hold_ready", 32'(bus.req_ready), 32'd0);
         @(posedge clk); #1;
         garble();
      end
      bus.req_valid = 1'b0;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("rdata", bus.rdata, e.rd);
         check("resp_err", 32'(bus.resp_err), 32'(e.er));
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      check("idle_after_resp", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      garble();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_outputs", {bus.rdata[29:0], bus.resp_err, bus.resp_valid}, 32'd0);
      check("reset_ready", 32'(bus.req_ready), 32'd1);

      // SW / LW round trip
      issue(1, 0, 32'h10, 32'hDEADBEEF, 8'h0F, 3'b010, 0);
      issue(0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 0);
      // Byte store with sign/zero-extended reloads
      issue(1, 0, 32'h10, 32'h0, 8'h0F, 3'b010, 0);
      issue(1, 0, 32'h11, 32'h80, 8'h01, 3'b000, 0);
      issue(0, 1, 32'h11, 32'h0, 8'h00, 3'b000, 0);
      issue(0, 1, 32'h11, 32'h0, 8'h00, 3'b100, 0);
      issue(0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 0);
      // Misaligned half load is an error; word unchanged
      issue(0, 1, 32'h13, 32'h0, 8'h00, 3'b001, 0);
      issue(0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 0);
      // Illegal stores must not write
      issue(1, 0, 32'h12, 32'hFFFFFFFF, 8'h0F, 3'b000, 0);
      issue(1, 1, 32'h10, 32'hFFFFFFFF, 8'h0F, 3'b010, 0);
      issue(1, 0, 32'h10, 32'hFFFFFFFF, 8'h07, 3'b000, 0);
      issue(0, 1, 32'h10, 32'h0, 8'h00, 3'b011, 0);
      issue(0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 0);
      // Backpressure in RESP
      issue(0, 1, 32'h10, 32'h0, 8'h00, 3'b010, 5);
      // Reset during WAIT aborts the store
      issue(1, 0, 32'h20, 32'hA5A5A5A5, 8'h0F, 3'b010, 0);
      bus.mem_wen   = 1'b1;
      bus.mem_ren   = 1'b0;
      bus.addr      = 32'h20;
      bus.wdata     = 32'h12345678;
      bus.wmask     = 8'h0F;
      bus.rmask     = 3'b010;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("accepted_before_rst", 32'(bus.req_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_wait_outputs", {bus.rdata[29:0], bus.resp_err, bus.resp_valid}, 32'd0);
      check("rst_wait_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      issue(0, 1, 32'h20, 32'h0, 8'h00, 3'b010, 0);
      // Address wrap modulo DEPTH words
      issue(1, 0, 32'h1000, 32'h0BADF00D, 8'h0F, 3'b010, 0);
      issue(0, 1, 32'h0, 32'h0, 8'h00, 3'b010, 0);
      // Randomised mix over a pre-initialised window
      for (int i = 0; i < 8; i++) begin
         issue(1, 0, 32'h100 + 32'(4 * i), $urandom, 8'h0F, 3'b010, 0);
      end
      for (int i = 0; i < 40; i++) begin
         logic [7:0] wm;
         case ($urandom_range(0, 3))
            0:       wm = 8'h01;
            1:       wm = 8'h03;
            2:       wm = 8'h0F;
            default: wm = 8'h07;
         endcase
         issue(1'($urandom), 1'($urandom), 32'h100 + 32'($urandom_range(0, 31)), $urandom,
               wm, 3'($urandom), $urandom_range(0, 2));
      end
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
